// File: rtl/mem_access_arbiter_pkg.sv
// Shared encodings for the CPU memory-access path: FSM states, RAM
// direction/size codes and requester identifiers.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_WAIT_LOW
    } state_t;

    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;
    localparam logic TYPE_WORD = 1'b0;
    localparam logic TYPE_BYTE = 1'b1;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

    // Word accesses must sit on a 4-byte boundary; bytes may go anywhere.
    function automatic logic misaligned(input logic type_data, input logic [1:0] lsb);
        return (type_data == TYPE_WORD) && (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// RAM-side MOV/MOC bus: the arbiter drives the operation, the RAM answers
// with MOC and read data.
interface mem_access_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic          MOV;
    logic          RW;
    logic          typeData;
    logic [AW-1:0] address;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          MOC;

    modport master (
        output MOV, RW, typeData, address, ram_wdata,
        input  ram_rdata, MOC
    );

    modport slave (
        input  MOV, RW, typeData, address, ram_wdata,
        output ram_rdata, MOC
    );
endinterface

// File: rtl/mem_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module mem_rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    gnt_t last_grant;

    always_comb begin
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == GNT_DATA) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_DATA;
        end else if (update && (|req)) begin
            last_grant <= grant[1] ? GNT_DATA : GNT_FETCH;
        end
    end
endmodule

// File: rtl/mem_access_arbiter.sv
// Sequences fetch and data accesses onto the shared RAM through the
// four-phase MOV/MOC handshake, with sizing, alignment and MOC timeout.
module mem_access_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic          if_err,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic          d_typeData,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    mem_access_arbiter_if.master mem
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t        state;
    gnt_t          cur;
    logic [CW-1:0] cnt;
    logic [1:0]    req;
    logic [1:0]    grant;
    logic          arb_update;
    logic [AW-1:0] sel_addr;
    logic          sel_rw;
    logic          sel_type;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] rd_fmt;

    assign req        = {d_req, if_req};
    assign arb_update = (state == ST_IDLE);

    mem_rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (CLR),
        .req    (req),
        .update (arb_update),
        .grant  (grant)
    );

    // Fetch is always a word read; data side carries its own direction/size.
    always_comb begin
        sel_addr  = grant[1] ? d_addr : if_addr;
        sel_rw    = grant[1] ? d_rw : RW_READ;
        sel_type  = grant[1] ? d_typeData : TYPE_WORD;
        sel_wdata = '0;
        if (grant[1]) begin
            sel_wdata = (d_typeData == TYPE_BYTE) ? {{(DW-8){1'b0}}, d_wdata[7:0]} : d_wdata;
        end
        rd_fmt = (mem.typeData == TYPE_BYTE) ? {{(DW-8){1'b0}}, mem.ram_rdata[7:0]}
                                             : mem.ram_rdata;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state         <= ST_IDLE;
            cur           <= GNT_FETCH;
            cnt           <= '0;
            mem.MOV       <= 1'b0;
            mem.RW        <= RW_READ;
            mem.typeData  <= TYPE_WORD;
            mem.address   <= '0;
            mem.ram_wdata <= '0;
            if_done       <= 1'b0;
            if_err        <= 1'b0;
            if_rdata      <= '0;
            d_done        <= 1'b0;
            d_err         <= 1'b0;
            d_rdata       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        cur           <= grant[1] ? GNT_DATA : GNT_FETCH;
                        cnt           <= '0;
                        mem.RW        <= sel_rw;
                        mem.typeData  <= sel_type;
                        mem.address   <= sel_addr;
                        mem.ram_wdata <= sel_wdata;
                        // Misaligned word: answer with an error without touching RAM.
                        if (misaligned(sel_type, sel_addr[1:0])) begin
                            state <= ST_RESP;
                            if (grant[1]) begin
                                d_done <= 1'b1;
                                d_err  <= 1'b1;
                            end else begin
                                if_done <= 1'b1;
                                if_err  <= 1'b1;
                            end
                        end else begin
                            mem.MOV <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // MOC is checked first so it wins over a same-edge expiry.
                    if (mem.MOC) begin
                        mem.MOV <= 1'b0;
                        state   <= ST_RESP;
                        if (cur == GNT_DATA) begin
                            d_done <= 1'b1;
                            d_err  <= 1'b0;
                            if (mem.RW == RW_READ) d_rdata <= rd_fmt;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= 1'b0;
                            if_rdata <= rd_fmt;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        mem.MOV <= 1'b0;
                        state   <= ST_RESP;
                        if (cur == GNT_DATA) begin
                            d_done <= 1'b1;
                            d_err  <= 1'b1;
                        end else begin
                            if_done <= 1'b1;
                            if_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if_done <= 1'b0;
                    if_err  <= 1'b0;
                    d_done  <= 1'b0;
                    d_err   <= 1'b0;
                    state   <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!mem.MOC) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter; the bench plays the RAM by hand.
module tb_mem_access_arbiter;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_done;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_rw;
    logic        d_typeData;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic        d_err;
    logic [31:0] d_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_arbiter_if #(.AW(8), .DW(32)) bus ();

    mem_access_arbiter #(.TIMEOUT(15), .AW(8), .DW(32)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_err     (if_err),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_rw       (d_rw),
        .d_typeData (d_typeData),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_err      (d_err),
        .d_rdata    (d_rdata),
        .mem        (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) until MOV is seen; n is the number of edges it took.
    task automatic wait_mov(output bit seen, output int n);
        n = 0;
        while (bus.MOV !== 1'b1 && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        seen = (bus.MOV === 1'b1);
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        if_req = 0; if_addr = '0; d_req = 0; d_rw = 1; d_typeData = 0;
        d_addr = '0; d_wdata = '0; bus.MOC = 0; bus.ram_rdata = '0;
        repeat (2) @(posedge CLK); #1;
        checks++; if (bus.MOV !== 1'b0) begin errors++; $display("FAIL reset_mov: got %b expected 0", bus.MOV); end
        checks++; if (bus.RW !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b expected 1", bus.RW); end
        checks++; if (bus.typeData !== 1'b0) begin errors++; $display("FAIL reset_type: got %b expected 0", bus.typeData); end
        checks++; if (bus.address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", bus.address); end
        checks++; if (bus.ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.ram_wdata); end
        checks++; if ({if_done, if_err, d_done, d_err} !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", {if_done, if_err, d_done, d_err}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata); end
        @(negedge CLK) CLR = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_round_robin();
        bit seen; int n; logic [7:0] exp_addr; logic [1:0] exp_done; logic [31:0] got;
        if_addr = 8'h08; d_addr = 8'h20; d_rw = 1; d_typeData = 0;
        if_req = 1; d_req = 1;
        for (int i = 0; i < 4; i++) begin
            wait_mov(seen, n);
            checks++; if (!seen) begin errors++; $display("FAIL rr_mov[%0d]: got 0 expected 1", i); end
            exp_addr = (i % 2 == 0) ? 8'h08 : 8'h20;
            checks++; if (bus.address !== exp_addr) begin errors++; $display("FAIL rr_grant[%0d]: got addr %h expected %h", i, bus.address, exp_addr); end
            bus.ram_rdata = 32'hA000_0000 + i; bus.MOC = 1;
            @(posedge CLK); #1;
            exp_done = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if ({if_done, d_done} !== exp_done) begin errors++; $display("FAIL rr_done[%0d]: got %b expected %b", i, {if_done, d_done}, exp_done); end
            got = (i % 2 == 0) ? if_rdata : d_rdata;
            checks++; if (got !== 32'hA000_0000 + i) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, got, 32'hA000_0000 + i); end
            bus.MOC = 0;
            if (i == 3) begin if_req = 0; d_req = 0; end
        end
    endtask

    task automatic test_fetch_read();
        bit seen; int n;
        repeat (3) @(posedge CLK); #1;
        if_addr = 8'h04; if_req = 1;
        wait_mov(seen, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL fetch_latency: got %0d edges expected 1", n); end
        checks++; if ({bus.address, bus.RW, bus.typeData} !== {8'h04, 1'b1, 1'b0}) begin errors++; $display("FAIL fetch_cmd: got %h/%b/%b expected 04/1/0", bus.address, bus.RW, bus.typeData); end
        bus.ram_rdata = 32'hE7D12000; bus.MOC = 1;
        @(posedge CLK); #1;
        checks++; if ({if_done, if_err, d_done, bus.MOV} !== 4'b1000) begin errors++; $display("FAIL fetch_done: got %b expected 1000", {if_done, if_err, d_done, bus.MOV}); end
        checks++; if (if_rdata !== 32'hE7D12000) begin errors++; $display("FAIL fetch_rdata: got %h expected e7d12000", if_rdata); end
        if_req = 0; bus.MOC = 0; bus.ram_rdata = 32'h0;
        @(posedge CLK); #1;
        checks++; if (if_done !== 1'b0 || if_rdata !== 32'hE7D12000) begin errors++; $display("FAIL fetch_hold: got %b/%h expected 0/e7d12000", if_done, if_rdata); end
    endtask

    task automatic test_byte_write_read();
        bit seen; int n;
        repeat (3) @(posedge CLK); #1;
        d_rw = 0; d_typeData = 1; d_addr = 8'h13; d_wdata = 32'h12345678; d_req = 1;
        wait_mov(seen, n);
        checks++; if ({seen, bus.RW, bus.typeData, bus.address} !== {1'b1, 1'b0, 1'b1, 8'h13}) begin errors++; $display("FAIL bw_cmd: got %b/%b/%b/%h expected 1/0/1/13", seen, bus.RW, bus.typeData, bus.address); end
        checks++; if (bus.ram_wdata !== 32'h00000078) begin errors++; $display("FAIL bw_wdata: got %h expected 00000078", bus.ram_wdata); end
        bus.ram_rdata = 32'hDEADBEEF; bus.MOC = 1;
        @(posedge CLK); #1;
        checks++; if ({d_done, d_err} !== 2'b10) begin errors++; $display("FAIL bw_done: got %b expected 10", {d_done, d_err}); end
        checks++; if (d_rdata !== 32'hA0000003) begin errors++; $display("FAIL bw_rdata_kept: got %h expected a0000003", d_rdata); end
        d_req = 0; bus.MOC = 0;
        repeat (3) @(posedge CLK); #1;
        d_rw = 1; d_req = 1;
        wait_mov(seen, n);
        checks++; if ({seen, bus.RW, bus.typeData} !== 3'b111) begin errors++; $display("FAIL br_cmd: got %b expected 111", {seen, bus.RW, bus.typeData}); end
        bus.ram_rdata = 32'hFFFFFFAB; bus.MOC = 1;
        @(posedge CLK); #1;
        checks++; if ({d_done, d_err} !== 2'b10 || d_rdata !== 32'h000000AB) begin errors++; $display("FAIL br_rdata: got %b/%h expected 10/000000ab", {d_done, d_err}, d_rdata); end
        d_req = 0; bus.MOC = 0;
    endtask

    task automatic test_misaligned();
        bit mov_seen = 0; bit got_done = 0; bit got_err = 0;
        repeat (3) @(posedge CLK); #1;
        d_rw = 1; d_typeData = 0; d_addr = 8'h02; d_req = 1;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            if (bus.MOV === 1'b1) mov_seen = 1;
            if (d_done === 1'b1) begin got_done = 1; got_err = d_err; d_req = 0; end
        end
        d_req = 0;
        checks++; if (mov_seen !== 1'b0) begin errors++; $display("FAIL mis_mov: got 1 expected 0"); end
        checks++; if ({got_done, got_err} !== 2'b11) begin errors++; $display("FAIL mis_err: got %b expected 11", {got_done, got_err}); end
        checks++; if (d_rdata !== 32'h000000AB) begin errors++; $display("FAIL mis_rdata: got %h expected 000000ab", d_rdata); end
    endtask

    task automatic test_timeout();
        bit seen; int n; int high;
        repeat (3) @(posedge CLK); #1;
        d_rw = 1; d_typeData = 0; d_addr = 8'h40; d_req = 1;
        wait_mov(seen, n);
        high = seen ? 1 : 0;
        while (bus.MOV === 1'b1 && high < 40) begin
            @(posedge CLK); #1;
            if (bus.MOV === 1'b1) high++;
        end
        checks++; if (high !== 15) begin errors++; $display("FAIL to_cycles: got %0d expected 15", high); end
        checks++; if ({d_done, d_err} !== 2'b11) begin errors++; $display("FAIL to_err: got %b expected 11", {d_done, d_err}); end
        checks++; if (d_rdata !== 32'h000000AB) begin errors++; $display("FAIL to_rdata: got %h expected 000000ab", d_rdata); end
        d_req = 0;
    endtask

    task automatic test_moc_race();
        bit seen; int n;
        repeat (3) @(posedge CLK); #1;
        d_rw = 1; d_typeData = 0; d_addr = 8'h44; d_req = 1;
        wait_mov(seen, n);
        for (int k = 1; k < 15; k++) begin
            @(posedge CLK); #1;
        end
        checks++; if (bus.MOV !== 1'b1) begin errors++; $display("FAIL race_mov: got %b expected 1", bus.MOV); end
        bus.ram_rdata = 32'hCAFEF00D; bus.MOC = 1;
        @(posedge CLK); #1;
        checks++; if ({d_done, d_err} !== 2'b10 || d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL race_win: got %b/%h expected 10/cafef00d", {d_done, d_err}, d_rdata); end
        d_req = 0; bus.MOC = 0;
    endtask

    task automatic test_clr_mid();
        bit seen; int n; bit done_seen = 0; bit mov_seen = 0;
        repeat (3) @(posedge CLK); #1;
        if_addr = 8'h10; if_req = 1;
        wait_mov(seen, n);
        #1 CLR = 1'b1;
        #1;
        checks++; if ({bus.MOV, bus.address} !== {1'b0, 8'h00}) begin errors++; $display("FAIL clr_async: got %b/%h expected 0/00", bus.MOV, bus.address); end
        if_req = 0;
        #1 CLR = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            if (if_done === 1'b1 || d_done === 1'b1) done_seen = 1;
            if (bus.MOV === 1'b1) mov_seen = 1;
        end
        checks++; if ({done_seen, mov_seen} !== 2'b00) begin errors++; $display("FAIL clr_lost: got %b expected 00", {done_seen, mov_seen}); end
        if_addr = 8'h14; if_req = 1;
        wait_mov(seen, n);
        checks++; if ({seen, bus.address} !== {1'b1, 8'h14}) begin errors++; $display("FAIL clr_next_cmd: got %b/%h expected 1/14", seen, bus.address); end
        bus.ram_rdata = 32'h5555AAAA; bus.MOC = 1;
        @(posedge CLK); #1;
        checks++; if ({if_done, if_err} !== 2'b10 || if_rdata !== 32'h5555AAAA) begin errors++; $display("FAIL clr_next_done: got %b/%h expected 10/5555aaaa", {if_done, if_err}, if_rdata); end
        if_req = 0; bus.MOC = 0;
        repeat (3) @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fetch_read();
        test_byte_write_read();
        test_misaligned();
        test_timeout();
        test_moc_race();
        test_clr_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
